rice_sample_rebuilder: RTL and testbench
========================================

// Module: rice_sample_rebuilder
// PURPOSE
//  Downstream of the OR-plane / priority-encoder stage. Per sample, takes the decoded
//  fundamental-sequence count (fs) and k split bits and forms the mapped residual
//  delta = (fs << k) | kbits. Optionally inverse-maps delta through a unit-delay
//  predictor to a reconstructed sample, then buffers results in a small show-ahead
//  FIFO. Samples are emitted in blocks of j, with valid/ready on both sides.
// PARAMETERS
//  N           16  sample width; also the delta width
//  FIFO_DEPTH  8   output FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-high
//  start        in   1    1-cycle pulse; opens a block (ignored unless IDLE)
//  j            in   5    block length in samples, sampled on start; 0 = start ignored
//  k            in   5    split-bit count, sampled per input beat; must be <= N-1
//  ref_en       in   1    sampled on start; first beat of block is a raw reference
//  in_valid     in   1    fs/kbits beat valid
//  in_ready     out  1    beat accepted when in_valid & in_ready
//  fs_in        in   5    fsdecoded from upstream
//  kbits_in     in   N    split bits in [k-1:0]; upper bits ignored; whole word = ref sample
//  out_valid    out  1    FIFO not empty
//  out_ready    in   1    pop when out_valid & out_ready
//  sample_out   out  N    FIFO head
//  block_done   out  1    1-cycle pulse: j-th beat of block written to FIFO
//  err          out  1    sticky: delta overflowed N bits; cleared by accepted start
//  busy         out  1    state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, x_prev=0, err=0; all outputs 0.
//  FSM: IDLE --start & j!=0--> (ref_en ? REF : DATA). REF --accept--> DATA (or IDLE if j==1).
//   DATA --accept of j-th beat--> IDLE. start in REF/DATA has no effect.
//  Beat counter: loaded with j on start, decrements per accepted beat; the REF beat counts.
//  in_ready = (state==REF|DATA) & ~fifo_full. No full-bypass: a pop and an attempted
//   push in the same full cycle still refuse the push; in_ready rises the cycle after the pop.
//  Arithmetic: mask = (1<<k)-1; delta = ({fs,N'b0} >> (N-k)) ... formed as
//   (fs << k) | (kbits & mask), computed in N+5 bits. Any set bit above N-1 sets err.
//   The stored value is truncated to N bits.
//  REF beat: sample = kbits_in (all N bits), fs ignored, no overflow check; x_prev <= sample.
//  Latency: accepted beat -> out_valid/sample_out on the next cycle (registered FIFO write).
//   A simultaneous pop and push on a non-empty FIFO leaves the count unchanged.
//  block_done asserts in the cycle after the last accept, coincident with its FIFO visibility.
//  Reset mid-block: the block is abandoned, the FIFO is flushed, and no block_done is produced.
//  x_prev persists across blocks. It is re-zeroed only by reset or overwritten by a REF beat.
// CONFIGURATION
//  RICE_PREDICTOR_EN defined: each DATA beat is inverse-mapped.
//   Compute theta = min(x_prev, 2^N-1-x_prev).
//   If delta <= 2*theta: Delta = delta even ? delta/2 : -(delta+1)/2.
//   Else if theta == x_prev: Delta = delta - theta; else Delta = theta - delta.
//   sample = x_prev + Delta (mod 2^N, in range by construction); x_prev <= sample.
//  Undefined: sample = delta; x_prev is still updated, and REF beats are still passed raw.
// TESTING
//  1 reset mid-block (after 2 of 5 beats) -> out_valid=0, busy=0, no block_done; next start works.
//  2 no macro, k=2, fs=3, kbits=01, j=1, ref_en=0 -> sample_out=13 one cycle later;
//    block_done pulses in the same cycle; busy drops.
//  3 macro, ref_en=1, j=3: ref kbits=100, then delta=13, then delta=8 -> samples 100, 93, 97.
//  4 macro, far-side branch: ref 5, then delta=20 -> 20; ref 65530, then delta=20 -> 65515.
//  5 overflow: fs=31, k=15 -> err=1, sample_out = low 16 bits (0x8000);
//    err stays high until the next accepted start.
//  6 backpressure, FIFO_DEPTH=8, j=12, out_ready=0 -> 8 accepted, then in_ready=0;
//    raise out_ready -> 12 samples emitted in order, exactly one block_done.

Source files
------------

// File: rtl/rice_sample_rebuilder_if.sv
// rice_sample_rebuilder_if
//   Groups the control, input-beat and output-FIFO signals of
//   rice_sample_rebuilder.
//   master : the side that drives start/j/ref_en, the beats and out_ready
//            (upstream decoder plus downstream consumer).
//   slave  : the rebuilder itself.
//   Signals:
//     start, j, ref_en            block open request, length, reference flag
//     in_valid/in_ready           beat handshake; k, fs_in, kbits_in carry the beat
//     out_valid/out_ready         FIFO head handshake; sample_out is the head
//     block_done, err, busy       status
interface rice_sample_rebuilder_if #(
  parameter int N = 16
);
  logic         start;
  logic [4:0]   j;
  logic         ref_en;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   k;
  logic [4:0]   fs_in;
  logic [N-1:0] kbits_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sample_out;
  logic         block_done;
  logic         err;
  logic         busy;

  modport master (
    output start, j, ref_en, in_valid, k, fs_in, kbits_in, out_ready,
    input  in_ready, out_valid, sample_out, block_done, err, busy
  );

  modport slave (
    input  start, j, ref_en, in_valid, k, fs_in, kbits_in, out_ready,
    output in_ready, out_valid, sample_out, block_done, err, busy
  );
endinterface

// File: rtl/rice_sample_rebuilder.sv
// rice_sample_rebuilder
//   Rebuilds Rice-coded samples from the decoded fundamental-sequence count
//   and the k split bits: delta = (fs << k) | (kbits & ((1<<k)-1)).
//   Results pass through a show-ahead FIFO; samples are grouped in blocks
//   of j beats, the first of which may be a raw reference sample.
//   Optional feature macro RICE_PREDICTOR_EN: when defined, each non-reference
//   beat is inverse-mapped through a unit-delay predictor (x_prev).
//   Without it the stored sample is delta itself. With no predictor nothing
//   consumes x_prev, so the register exists only in the predictor build.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    rice_sample_rebuilder_if.slave (beat input, FIFO output, status)
// Parameters:
//   N           sample / delta width
//   FIFO_DEPTH  output FIFO entries, power of two, >= 2
//
// state | meaning
// IDLE  | no block open, beats refused, start accepted when j != 0
// REF   | next beat is the raw reference sample of the block
// DATA  | beats are mapped residuals until the block count runs out
module rice_sample_rebuilder #(
  parameter int N          = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  rice_sample_rebuilder_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REF  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [N-1:0] ONE_N = 1;

  logic [1:0]   state;
  logic [4:0]   beat_cnt;
  logic         err_q;
  logic         done_q;

  logic [N-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic         fifo_full;
  logic         fifo_nonempty;
  logic         ready;
  logic         accept;
  logic         pop;
  logic         start_ok;
  logic         last_beat;

  logic [N-1:0] mask;
  logic [N+4:0] delta_wide;
  logic [N-1:0] delta;
  logic         ovf;
  logic [N-1:0] data_sample;
  logic [N-1:0] sample_next;

  assign fifo_full     = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_nonempty = (count != '0);
  // No bypass when full: a pop in the same cycle does not open room for a push.
  assign ready     = (state != S_IDLE) && !fifo_full;
  assign accept    = bus.in_valid && ready;
  assign pop       = fifo_nonempty && bus.out_ready;
  assign start_ok  = bus.start && (state == S_IDLE) && (bus.j != 5'd0);
  assign last_beat = (beat_cnt == 5'd1);

  // Delta is built N+5 bits wide so that bits shifted past N-1 reveal overflow.
  assign mask       = (ONE_N << bus.k) - ONE_N;
  assign delta_wide = ({{N{1'b0}}, bus.fs_in} << bus.k) | {5'b0, bus.kbits_in & mask};
  assign delta      = delta_wide[N-1:0];
  assign ovf        = |delta_wide[N+4:N];

`ifdef RICE_PREDICTOR_EN
  logic [N-1:0] x_prev;
  logic [N-1:0] theta;

  // theta is the distance from x_prev to the nearer end of the N-bit range;
  // ~x_prev equals 2^N-1-x_prev.
  assign theta = (x_prev <= ~x_prev) ? x_prev : ~x_prev;

  always_comb begin
    data_sample = x_prev;
    if ({1'b0, delta} <= {theta, 1'b0}) begin
      // Interleaved region: even codes step up, odd codes step down.
      // For odd delta, (delta+1)/2 == (delta>>1) + 1.
      if (!delta[0]) data_sample = x_prev + (delta >> 1);
      else           data_sample = x_prev - (delta >> 1) - ONE_N;
    end else if (theta == x_prev) begin
      data_sample = x_prev + delta - theta;
    end else begin
      data_sample = x_prev + theta - delta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       x_prev <= '0;
    else if (accept) x_prev <= sample_next;
  end
`else
  assign data_sample = delta;
`endif

  assign sample_next = (state == S_REF) ? bus.kbits_in : data_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= accept && last_beat;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            beat_cnt <= bus.j;
            err_q    <= 1'b0;
            state    <= bus.ref_en ? S_REF : S_DATA;
          end
        end
        S_REF, S_DATA: begin
          if (accept) begin
            beat_cnt <= beat_cnt - 5'd1;
            state    <= last_beat ? S_IDLE : S_DATA;
            if ((state == S_DATA) && ovf) err_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; reset flushes by clearing pointers and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= sample_next;
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = fifo_nonempty;
  assign bus.sample_out = fifo_nonempty ? mem[rd_ptr] : '0;
  assign bus.block_done = done_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_rice_sample_rebuilder.sv
module tb_rice_sample_rebuilder;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rice_sample_rebuilder_if #(.N(N)) bus();

  rice_sample_rebuilder #(.N(N), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int k;
    int fs;
    int kb;
    bit is_ref;
  } beat_t;

  typedef struct {
    bit re;
    int k;
    int fs;
    int kb;
    int exp_raw;
    int exp_pred;
    bit exp_err;
  } vec_t;

  int    n_cmp = 0;
  int    n_mis = 0;
  int    m_x   = 0;
  bit    m_err = 1'b0;
  int    bd_cnt = 0;
  beat_t pend[$];
  int    exp_q[$];
  int    got_q[$];
  vec_t  tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: straight arithmetic on the rebuild and inverse-map rules.
  function automatic int model_beat(input bit is_ref, input int kk, input int fs, input int kb);
    int delta_full, delta, theta, d, s;
    if (is_ref) begin
      s = kb % 65536;
      m_x = s;
      return s;
    end
    delta_full = fs * (1 << kk) + (kb % (1 << kk));
    if (delta_full >= 65536) m_err = 1'b1;
    delta = delta_full % 65536;
`ifdef RICE_PREDICTOR_EN
    theta = (m_x < 65535 - m_x) ? m_x : 65535 - m_x;
    if (delta <= 2 * theta) d = (delta % 2 == 0) ? delta / 2 : -((delta + 1) / 2);
    else if (theta == m_x)  d = delta - theta;
    else                    d = theta - delta;
    s = ((m_x + d) % 65536 + 65536) % 65536;
`else
    theta = 0;
    d = 0;
    s = delta;
`endif
    m_x = s;
    return s;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back(int'(bus.sample_out));
      if (bus.block_done) bd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_blk(input int jj, input bit re);
    bus.start  = 1'b1;
    bus.j      = jj[4:0];
    bus.ref_en = re;
    tick();
    bus.start  = 1'b0;
    if (jj != 0) m_err = 1'b0;
  endtask

  task automatic queue_beat(input bit re, input int kk, input int fs, input int kb);
    beat_t b;
    b.k = kk; b.fs = fs; b.kb = kb; b.is_ref = re;
    pend.push_back(b);
    exp_q.push_back(model_beat(re, kk, fs, kb));
  endtask

  task automatic queue_random_block(input int jj, input bit re);
    int kk, fs, lim;
    for (int i = 0; i < jj; i++) begin
      kk  = $urandom_range(0, 15);
      lim = ((65535 >> kk) > 31) ? 31 : (65535 >> kk);
      fs  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, lim);
      queue_beat(re && (i == 0), kk, fs, $urandom_range(0, 65535));
    end
  endtask

  task automatic feed(input int max_cyc, input bit gaps, output int acc);
    bit take;
    acc = 0;
    for (int c = 0; c < max_cyc && pend.size() > 0; c++) begin
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (gaps) bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.k        = 5'(pend[0].k);
      bus.fs_in    = 5'(pend[0].fs);
      bus.kbits_in = N'(pend[0].kb);
      @(negedge clk);
      take = bus.in_valid && bus.in_ready;
      tick();
      if (take) begin
        void'(pend.pop_front());
        acc++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    bus.out_ready = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (!bus.out_valid) break;
      tick();
    end
    chk("drain_empty", bus.out_valid, 0);
  endtask

  task automatic compare_q(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk(name, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    int acc;
    int bd0;
    int jj;
    bit re;
    int exp_s;

    tbl[0] = '{1, 0,  0, 100,      100,   100,   0};
    tbl[1] = '{0, 2,  3, 1,        13,    93,    0};
    tbl[2] = '{0, 3,  1, 0,        8,     97,    0};
    tbl[3] = '{1, 0,  0, 5,        5,     5,     0};
    tbl[4] = '{0, 4,  1, 4,        20,    20,    0};
    tbl[5] = '{1, 0,  0, 65530,    65530, 65530, 0};
    tbl[6] = '{0, 4,  1, 'hFFF4,   20,    65515, 0};
    tbl[7] = '{0, 0,  7, 'hFFFF,   7,     65511, 0};
    tbl[8] = '{0, 15, 31, 0,       32768, 32767, 1};
    tbl[9] = '{0, 15, 1, 'h7FFF,   65535, 65535, 0};

    reset = 1'b1;
    bus.start = 1'b0; bus.j = '0; bus.ref_en = 1'b0;
    bus.in_valid = 1'b0; bus.k = '0; bus.fs_in = '0; bus.kbits_in = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  bus.out_valid, 0);
    chk("rst_busy",       bus.busy, 0);
    chk("rst_in_ready",   bus.in_ready, 0);
    chk("rst_err",        bus.err, 0);
    chk("rst_block_done", bus.block_done, 0);
    chk("rst_sample_out", bus.sample_out, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Single-beat blocks; x_prev carries between them.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start_blk(1, tbl[i].re);
      chk("tbl_busy_open", bus.busy, 1);
      queue_beat(tbl[i].re, tbl[i].k, tbl[i].fs, tbl[i].kb);
      feed(10, 1'b0, acc);
      chk("tbl_accepted", acc, 1);
`ifdef RICE_PREDICTOR_EN
      exp_s = tbl[i].exp_pred;
`else
      exp_s = tbl[i].exp_raw;
`endif
      chk("tbl_out_valid",  bus.out_valid, 1);
      chk("tbl_sample",     bus.sample_out, exp_s);
      chk("tbl_block_done", bus.block_done, 1);
      chk("tbl_busy_done",  bus.busy, 0);
      chk("tbl_err",        bus.err, tbl[i].exp_err);
      tick();
      chk("tbl_done_pulse", bus.block_done, 0);
      chk("tbl_popped",     bus.out_valid, 0);
    end
    got_q.delete();
    exp_q.delete();

    // j == 0 start is ignored.
    start_blk(0, 1'b0);
    chk("j0_busy",     bus.busy, 0);
    chk("j0_in_ready", bus.in_ready, 0);

    // Backpressure: 12-beat block against an 8-entry FIFO.
    bd_cnt = 0;
    bus.out_ready = 1'b0;
    start_blk(12, 1'b0);
    queue_random_block(12, 1'b0);
    feed(20, 1'b0, acc);
    chk("bp_accepted_full", acc, 8);
    chk("bp_in_ready_full", bus.in_ready, 0);
    chk("bp_out_valid",     bus.out_valid, 1);
    bus.out_ready = 1'b1;
    chk("bp_no_bypass",     bus.in_ready, 0);
    tick();
    chk("bp_ready_after_pop", bus.in_ready, 1);
    feed(40, 1'b0, acc);
    chk("bp_accepted_rest", acc, 4);
    drain(40);
    compare_q("bp_sample");
    chk("bp_block_done_count", bd_cnt, 1);
    chk("bp_busy", bus.busy, 0);

    // Reset after 2 of 5 beats.
    bus.out_ready = 1'b0;
    start_blk(5, 1'b0);
    queue_random_block(5, 1'b0);
    feed(2, 1'b0, acc);
    chk("mid_accepted", acc, 2);
    bd0 = bd_cnt;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_out_valid",  bus.out_valid, 0);
    chk("mid_busy",       bus.busy, 0);
    chk("mid_in_ready",   bus.in_ready, 0);
    chk("mid_block_done", bus.block_done, 0);
    @(negedge clk);
    reset = 1'b0;
    m_x = 0;
    m_err = 1'b0;
    pend.delete();
    exp_q.delete();
    got_q.delete();
    tick();
    repeat (3) tick();
    chk("mid_no_done", bd_cnt, bd0);
    bus.out_ready = 1'b1;
    start_blk(1, 1'b0);
    queue_beat(1'b0, 2, 3, 1);
    feed(10, 1'b0, acc);
    chk("post_rst_sample", bus.sample_out, 13);
    chk("post_rst_done",   bus.block_done, 1);
    chk("post_rst_busy",   bus.busy, 0);
    drain(10);
    compare_q("post_rst");

    // Overflow is sticky until the next accepted start.
    bus.out_ready = 1'b0;
    start_blk(2, 1'b0);
    queue_beat(1'b0, 15, 31, 0);
    queue_beat(1'b0, 1, 1, 0);
    feed(1, 1'b0, acc);
    chk("ovf_err",    bus.err, 1);
    chk("ovf_sample", bus.sample_out, exp_q[0]);
    feed(10, 1'b0, acc);
    chk("ovf_err_sticky", bus.err, 1);
    tick();
    chk("ovf_err_idle", bus.err, 1);
    start_blk(1, 1'b0);
    chk("ovf_err_cleared", bus.err, 0);
    queue_beat(1'b0, 3, 2, 5);
    feed(10, 1'b0, acc);
    chk("ovf_err_after", bus.err, 0);
    drain(20);
    compare_q("ovf_sample_q");

    // Randomized blocks with input gaps and random output stalls.
    bd_cnt = 0;
    for (int b = 0; b < 25; b++) begin
      jj = $urandom_range(1, 8);
      re = ($urandom_range(0, 1) == 1);
      start_blk(jj, re);
      queue_random_block(jj, re);
      feed(400, 1'b1, acc);
      chk("rnd_accepted", acc, jj);
      chk("rnd_err", bus.err, m_err);
      chk("rnd_busy", bus.busy, 0);
    end
    pend.delete();
    drain(200);
    compare_q("rnd_sample");
    chk("rnd_block_done_count", bd_cnt, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
